// File: rtl/sigmoid_alu_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sigmoid_alu_accumulator: bias + NUM_BEATS partial sums, shift, sat8.    |
// | Rev 1.0                                                                 |
// +--------------------------------------------------------------------------+
module sigmoid_alu_accumulator #(
  parameter int NUM_BEATS  = 196,
  parameter int ACC_WIDTH  = 19,
  parameter int FRAC_SHIFT = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              start,
  input  logic signed [7:0] bias_in,
  input  logic signed [9:0] sum_in,
  input  logic              sum_valid,
  output logic              sum_ready,
  output logic signed [7:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy
);

  localparam int c_CNT_W = $clog2(NUM_BEATS + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NUM_BEATS - 1);
  localparam logic signed [ACC_WIDTH-1:0] c_SAT_MAX = ACC_WIDTH'(127);
  localparam logic signed [ACC_WIDTH-1:0] c_SAT_MIN = ACC_WIDTH'(-128);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic        [c_CNT_W-1:0]    r_cnt;
  logic signed [7:0]            r_result;
  logic                         r_sum_ready;
  logic                         r_result_valid;
  logic                         r_busy;

  logic                         w_abort;
  logic                         w_accept;
  logic                         w_last;
  logic signed [ACC_WIDTH-1:0]  w_sum_ext;
  logic signed [ACC_WIDTH-1:0]  w_bias_ext;
  logic signed [ACC_WIDTH-1:0]  w_total;
  logic signed [ACC_WIDTH-1:0]  w_shifted;
  logic signed [7:0]            w_sat;

  // clear only acts once a neuron is in flight; in IDLE it must leave result alone
  assign w_abort    = clear && (r_state != S_IDLE);
  assign w_accept   = sum_valid && r_sum_ready;
  assign w_last     = w_accept && (r_cnt == c_LAST);
  assign w_sum_ext  = {{(ACC_WIDTH-10){sum_in[9]}}, sum_in};
  assign w_bias_ext = {{(ACC_WIDTH-8){bias_in[7]}}, bias_in};
  assign w_total    = r_acc + w_sum_ext;
  assign w_shifted  = w_total >>> FRAC_SHIFT;

  always_comb begin
    w_sat = w_shifted[7:0];
    if (w_shifted > c_SAT_MAX) begin
      w_sat = 8'sh7F;
    end else if (w_shifted < c_SAT_MIN) begin
      w_sat = 8'sh80;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start)        w_next = S_ACCUM;
        S_ACCUM: if (w_last)       w_next = S_DONE;
        S_DONE:  if (result_ready) w_next = S_IDLE;
        default:                   w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state        <= S_IDLE;
      r_sum_ready    <= 1'b0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_sum_ready    <= (w_next == S_ACCUM);
      r_result_valid <= (w_next == S_DONE);
      r_busy         <= (w_next != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst || w_abort) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= w_bias_ext;
            r_cnt <= '0;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_total;
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_last) begin
            r_result <= w_sat;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum_ready    = r_sum_ready;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign result       = r_result;

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_alu_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sigmoid_alu_accumulator: directed vectors for 4-beat and 196-beat.   |
// | Rev 1.0                                                                 |
// +--------------------------------------------------------------------------+
module tb_sigmoid_alu_accumulator;

  logic clk = 1'b0;
  logic n_rst, clear;
  always #5 clk = ~clk;

  logic              start, sum_valid, result_ready;
  logic signed [7:0] bias_in;
  logic signed [9:0] sum_in;
  logic              sum_ready, result_valid, busy;
  logic signed [7:0] result;

  logic              d_start, d_valid, d_rready;
  logic signed [7:0] d_bias;
  logic signed [9:0] d_sum;
  logic              d_sready, d_rvalid, d_busy;
  logic signed [7:0] d_result;

  sigmoid_alu_accumulator #(.NUM_BEATS(4), .ACC_WIDTH(19), .FRAC_SHIFT(2)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .start(start), .bias_in(bias_in),
    .sum_in(sum_in), .sum_valid(sum_valid), .sum_ready(sum_ready), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
  );

  sigmoid_alu_accumulator dut_d (
    .clk(clk), .n_rst(n_rst), .clear(clear), .start(d_start), .bias_in(d_bias),
    .sum_in(d_sum), .sum_valid(d_valid), .sum_ready(d_sready), .result(d_result),
    .result_valid(d_rvalid), .result_ready(d_rready), .busy(d_busy)
  );

  typedef struct {
    int bias;
    int s[4];
    int exp;
  } vec_t;

  vec_t vecs[10];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic beat(input int v);
    sum_valid = 1'b1;
    sum_in    = 10'(v);
    tick;
    sum_valid = 1'b0;
  endtask

  task automatic run4(input int bias, input int s[4], input int exp, input string tag);
    start   = 1'b1;
    bias_in = 8'(bias);
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) beat(s[i]);
    check({tag, " result_valid"}, int'(result_valid), 1);
    check({tag, " result"}, int'(result), exp);
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
    check({tag, " busy after handshake"}, int'(busy), 0);
    check({tag, " result_valid after handshake"}, int'(result_valid), 0);
  endtask

  task automatic run_d(input int bias, input int v, input int exp, input string tag);
    logic early;
    early   = 1'b0;
    d_start = 1'b1;
    d_bias  = 8'(bias);
    tick;
    d_start = 1'b0;
    d_valid = 1'b1;
    d_sum   = 10'(v);
    for (int i = 0; i < 196; i++) begin
      tick;
      if (i < 195 && d_rvalid) early = 1'b1;
    end
    d_valid = 1'b0;
    check({tag, " early result_valid"}, int'(early), 0);
    check({tag, " result_valid"}, int'(d_rvalid), 1);
    check({tag, " result"}, int'(d_result), exp);
    d_rready = 1'b1;
    tick;
    d_rready = 1'b0;
    check({tag, " busy after handshake"}, int'(d_busy), 0);
  endtask

  initial begin
    logic hold_bad;
    // bias, four sums, expected sat8((bias + sum) >>> 2)
    vecs[0] = '{0,    '{10, 20, 30, 40},         25};
    vecs[1] = '{127,  '{510, 510, 510, 510},     127};
    vecs[2] = '{-128, '{-512, -512, -512, -512}, -128};
    vecs[3] = '{0,    '{-1, 0, 0, 0},            -1};
    vecs[4] = '{0,    '{3, 0, 0, 0},             0};
    vecs[5] = '{5,    '{-20, 0, 0, 0},           -4};
    vecs[6] = '{1,    '{100, 100, 100, 100},     100};
    vecs[7] = '{0,    '{127, 127, 127, 127},     127};
    vecs[8] = '{0,    '{128, 128, 128, 128},     127};
    vecs[9] = '{0,    '{-129, -129, -129, -129}, -128};

    n_rst = 1'b0; clear = 1'b0;
    start = 1'b1; sum_valid = 1'b0; result_ready = 1'b0; bias_in = '0; sum_in = '0;
    d_start = 1'b0; d_valid = 1'b0; d_rready = 1'b0; d_bias = '0; d_sum = '0;
    tick;
    tick;
    check("reset sum_ready", int'(sum_ready), 0);
    check("reset result_valid", int'(result_valid), 0);
    check("reset busy (start held)", int'(busy), 0);
    check("reset result", int'(result), 0);
    check("reset default busy", int'(d_busy), 0);
    start = 1'b0;
    n_rst = 1'b1;
    tick;

    for (int v = 0; v < 10; v++) begin
      run4(vecs[v].bias, vecs[v].s, vecs[v].exp, $sformatf("vec%0d", v));
    end

    clear = 1'b1;
    tick;
    clear = 1'b0;
    check("clear in IDLE keeps result", int'(result), -128);

    // stalls and stray starts inside ACCUM, then DONE backpressure
    start = 1'b1; bias_in = 8'sd0;
    tick;
    start = 1'b0;
    beat(10);
    beat(20);
    sum_in = 10'sd99; start = 1'b1;
    for (int i = 0; i < 3; i++) tick;
    start = 1'b0;
    check("stall sum_ready", int'(sum_ready), 1);
    check("stall result_valid", int'(result_valid), 0);
    beat(30);
    beat(40);
    check("bp result_valid", int'(result_valid), 1);
    check("bp result", int'(result), 25);
    hold_bad = 1'b0;
    sum_valid = 1'b1; sum_in = 10'sd77; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (result_valid !== 1'b1 || result !== 8'sd25 || sum_ready !== 1'b0) hold_bad = 1'b1;
    end
    check("DONE hold stable", int'(hold_bad), 0);
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0; start = 1'b0; sum_valid = 1'b0;
    check("bp busy after handshake", int'(busy), 0);
    check("bp result_valid after handshake", int'(result_valid), 0);
    tick;
    check("start at handshake ignored", int'(busy), 0);
    check("result kept in IDLE", int'(result), 25);

    // clear mid-ACCUM
    start = 1'b1;
    tick;
    start = 1'b0;
    beat(10);
    beat(20);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    check("clear busy", int'(busy), 0);
    check("clear result_valid", int'(result_valid), 0);
    check("clear sum_ready", int'(sum_ready), 0);
    check("clear result", int'(result), 0);

    // reset mid-ACCUM after a completed result
    run4(vecs[6].bias, vecs[6].s, vecs[6].exp, "pre-reset");
    start = 1'b1;
    tick;
    start = 1'b0;
    beat(10);
    beat(20);
    n_rst = 1'b0;
    tick;
    n_rst = 1'b1;
    check("mid reset busy", int'(busy), 0);
    check("mid reset sum_ready", int'(sum_ready), 0);
    check("mid reset result_valid", int'(result_valid), 0);
    check("mid reset result", int'(result), 0);
    run4(vecs[0].bias, vecs[0].s, 25, "fresh");

    run_d(127, 510, 127, "default pos");
    run_d(-128, -512, -128, "default neg");
    run_d(0, 1, 12, "default small");
    run_d(-1, -1, -13, "default floor");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sigmoid_alu_accumulator.md
Name: sigmoid_ALU_accumulator

Overview:
Sequential neuron accumulator directly downstream of the sigmoid ALU 4-way adder. It consumes one signed 10-bit partial sum per beat and adds NUM_BEATS beats on top of a signed 8-bit bias. It then arithmetic-shifts the total, saturates it to signed 8 bits and presents it to the sigmoid lookup stage through a valid/ready handshake. Default config: one neuron of a 784-pixel input, 4 products per beat, so 196 beats.

Parameters:
NUM_BEATS, 196, number of partial sums accumulated per neuron (>=1)
ACC_WIDTH, 19, signed accumulator width; must hold NUM_BEATS*|-512| + 128 without overflow
FRAC_SHIFT, 4, arithmetic right-shift applied to the final total before saturation

Ports:
clk  input  1  system clock, all state updates on rising edge
n_rst  input  1  synchronous active-low reset
clear  input  1  synchronous abort; returns block to IDLE from any state
start  input  1  begin a neuron; sampled only in IDLE
bias_in  input  8  signed bias, captured on accepted start
sum_in  input  10  signed partial sum from the 4-way adder
sum_valid  input  1  sum_in is valid this cycle
sum_ready  output  1  block accepts sum_in this cycle (high only in ACCUM)
result  output  8  signed saturated neuron pre-activation
result_valid  output  1  result is valid; held until consumed
result_ready  input  1  downstream consumes result
busy  output  1  high in ACCUM and DONE

Behaviour:
- Reset (n_rst=0 at a rising edge): state IDLE, accumulator=0, beat counter=0, result=0, result_valid=0, sum_ready=0, busy=0. Reset overrides clear and start.
- Priority each edge: n_rst, then clear, then normal operation. clear: same effect as reset; it has no effect when already in IDLE.
- States IDLE, ACCUM, DONE. sum_ready=(state==ACCUM); result_valid=(state==DONE); busy=(state!=IDLE). All three are registered state decodes.
- IDLE: if start=1 then accumulator <= sign-extended bias_in, counter <= 0, next state ACCUM. Otherwise stay in IDLE.
- ACCUM: a beat is accepted when sum_valid && sum_ready. On acceptance: accumulator += sign-extended sum_in and counter += 1. sum_valid=0 is a stall; nothing changes.
- Acceptance of the NUM_BEATS-th beat at edge t: state DONE and result registered at the same edge, so result_valid is seen high in the cycle after the last beat. The last beat is included in the result.
- result = sat8(total >>> FRAC_SHIFT), where total = accumulator plus last beat. The shift is arithmetic and rounds toward -inf. Saturation: >127 gives 127 (0x7F), <-128 gives -128 (0x80).
- DONE: result and result_valid are held stable while result_ready=0. A handshake at edge t returns the block to IDLE, so result_valid=0 after t. result keeps its value until the next DONE or reset/clear.
- start outside IDLE is ignored. start in the same cycle as the DONE handshake is ignored; start must be reasserted in IDLE.
- sum_valid outside ACCUM is ignored; no beat is consumed.
- Counter width is $clog2(NUM_BEATS+1). The counter never wraps: it is cleared on start and the block leaves ACCUM at NUM_BEATS.
- No overflow logic inside the accumulator. Overflow is excluded by the ACC_WIDTH sizing rule; the default worst case is 196*(-512)-128 = -100480, which fits in 19 bits.
- Throughput: one beat per cycle in ACCUM. Minimum per-neuron time is 1 (start) + NUM_BEATS + 1 (DONE handshake) cycles.

Test Plan:
1. NUM_BEATS=4, FRAC_SHIFT=2, bias 0; sums 10, 20, 30, 40 on consecutive cycles, result_ready=1 -> result_valid high the cycle after the 4th beat with result=25. Next cycle IDLE, busy=0.
2. Saturation, same params. Positive: bias 127, sums 510 x4 (total 2167, >>>2 = 541) -> result=127. Negative: bias -128, sums -512 x4 (total -2176, >>>2 = -544) -> result=-128.
3. Floor rounding: bias 0, sums -1, 0, 0, 0 -> result=-1. Also bias 0, sums 3, 0, 0, 0 -> result=0.
4. Backpressure: deassert sum_valid for 3 cycles between beats 2 and 3 -> no extra beats counted, result still correct. In DONE, hold result_ready=0 for 5 cycles -> result_valid=1 and result unchanged throughout, sum_ready=0, extra sum_valid ignored. Raise result_ready -> IDLE next cycle.
5. Abort: after 2 accepted beats, assert clear for 1 cycle -> IDLE next cycle, busy=0, result_valid=0. Repeat with n_rst=0 mid-ACCUM -> all outputs 0. Then a fresh start with case-1 values -> result=25, no residue from the aborted run.
6. start pulsed during ACCUM and during the DONE handshake cycle -> ignored. Default params: 196 beats of 510, bias 127, FRAC_SHIFT=4 -> total 100087 gives result=127; 196 beats of -512, bias -128 -> result=-128. No accumulator wrap in either case.
